issue_decoder: RTL
==================

// Module: issue_decoder
// PURPOSE
//  Parametrised RV32I decode/issue stage between the instruction fetcher and the ROB, RS and LSB.
//  - Holds one decoded instruction in an output register under a valid/ready handshake, so back-pressure never drops an instruction.
//  - Renames operands from RegFile/ROB and captures results from N_CDB broadcast channels while it waits.
//  - Bypasses the destination of the instruction issuing in the same cycle, so one instruction issues per cycle.
// PARAMETERS
//  ROB_POS_W  4  ROB index width; tags are {pending, pos}, TAG_W = ROB_POS_W+1
//  N_CDB      2  number of result broadcast channels (ALU, LSB, ...)
// PORTS
//  clk  in  1  clock
//  rst  in  1  reset, synchronous, active-high
//  rdy  in  1  global enable; low = freeze all state
//  rollback  in  1  flush (mispredict)
//  inst_valid  in  1  fetcher has an instruction
//  inst_ready  out  1  decoder accepts this cycle
//  inst, inst_pc  in  32,32  instruction word, PC
//  reg_rs1, reg_rs2  out  5,5  RegFile query index (= inst[19:15], inst[24:20])
//  reg_rs1_val, reg_rs2_val  in  32,32  RegFile values
//  reg_rs1_tag, reg_rs2_tag  in  TAG_W,TAG_W  RegFile rename tags
//  rob_rs1_pos, rob_rs2_pos  out  ROB_POS_W  ROB query (= tag[ROB_POS_W-1:0])
//  rob_rs1_ready, rob_rs2_ready  in  1,1  ROB entry done
//  rob_rs1_val, rob_rs2_val  in  32,32  ROB entry value
//  rob_full, rs_full, lsb_full  in  1,1,1  back-pressure
//  nxt_rob_pos  in  ROB_POS_W  ROB slot the next issue receives
//  cdb_valid  in  N_CDB  broadcast valid per channel
//  cdb_pos  in  N_CDB*ROB_POS_W  broadcast ROB pos (channel i at [i*ROB_POS_W +: ROB_POS_W])
//  cdb_val  in  N_CDB*32  broadcast value
//  issue, rs_en, lsb_en  out  1,1,1  dispatch pulses
//  rob_pos  out  ROB_POS_W  = nxt_rob_pos (combinational)
//  opcode, funct3, funct7  out  7,3,1  decoded fields; funct7 = inst[30]
//  rs1_val, rs2_val  out  32,32  operand values (0 while pending)
//  rs1_tag, rs2_tag  out  TAG_W,TAG_W  0 = ready, else {1,pos}
//  imm  out  32  sign-extended immediate per format
//  rd  out  5  destination register
//  pc  out  32  instruction PC
//  illegal  out  1  opcode not in RV32I
// BEHAVIOUR
//  - Reset or rollback: held-valid=0; issue/rs_en/lsb_en=0. All other outputs are don't-care but stay stable; rollback beats accept.
//  - rdy=0: no state change; inst_ready, issue, rs_en and lsb_en are all 0.
//  - Dispatch class:
//    - LSB: load, store.
//    - RS: OP, OP-IMM, BRANCH, JALR.
//    - ROB-only: JAL, LUI, AUIPC, FENCE, SYSTEM, illegal.
//  - fire = held_valid & !rob_full & !(class==RS & rs_full) & !(class==LSB & lsb_full).
//  - issue = fire; rs_en = fire & RS; lsb_en = fire & LSB. All combinational, one cycle each.
//  - inst_ready = rdy & !rollback & (!held_valid | fire). accept = inst_valid & inst_ready; held_valid <= accept | (held_valid & !fire).
//  - Operand resolution at accept, first match wins:
//    1. Bypass: fire & held rd!=0 & rsN==held rd -> tag={1,nxt_rob_pos}, val=0.
//    2. rsN==0 -> ready, 0.
//    3. RegFile tag pending=0 -> reg val.
//    4. rob_rsN_ready -> ROB val.
//    5. CDB channel i valid & pos match -> cdb_val (lowest i wins).
//    6. Else tag = reg tag, val=0.
//  - While held and tag pending: a CDB match in any cycle (rdy=1) loads val and clears tag. The value is visible on the next cycle's outputs.
//  - Unused operands are forced ready with val 0: rs2 for L, OP-IMM, JALR; rs1 and rs2 for JAL, LUI, AUIPC.
//  - imm per format (I, S, B, U, J); B and J have bit 0 = 0; R-type imm = 0.
//  - Boundary cases:
//    - Back-to-back issue with RAW on the previous rd resolves to the bypass tag, never the stale RegFile state.
//    - nxt_rob_pos wraps naturally at 2^ROB_POS_W.
// STRUCTURE
//  - Shared macros: opcode constants, dispatch-class encoding, TAG_W, imm-format helper.
//  - One sub-module, issue_operand: per-operand resolve-at-accept plus CDB-capture register, instantiated twice.
// TESTING
//  - Reset -> issue=0, inst_ready=1. ADDI x1,x0,5 -> next cycle issue=1, rs_en=1, imm=5, rs1_tag=0, rs1_val=0.
//  - rs_full=1 with OP held: issue=0, inst_ready=0 for 3 cycles. Release -> one issue pulse, instruction unchanged.
//  - rs1 tag {1,3}, not ready; held; cdb_valid[1]=1, pos=3, val=0xDEAD -> next cycle rs1_tag=0, rs1_val=0xDEAD.
//  - ADD x5 issuing at nxt_rob_pos=7 while SUB x6,x5,x5 accepted -> SUB rs1_tag=rs2_tag={1,7}.
//  - Rollback with instruction held and inst_valid=1 -> held cleared, no issue next cycle, nothing accepted.
//  - LUI x2,0x12345 -> imm=0x12345000, rs_en=lsb_en=0, issue=1. Opcode 0x7F -> illegal=1, ROB-only issue.

Source files
------------

// File: rtl/issue_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_decoder_pkg
//  Description : Shared RV32I decode definitions for the issue stage:
//                opcode constants, dispatch classes, immediate formats and
//                small decode helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package issue_decoder_pkg;

    // Default ROB geometry. A tag is {pending, pos}, one bit wider than pos.
    localparam int DEF_ROB_POS_W = 4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        CLS_ROB = 2'd0,
        CLS_RS  = 2'd1,
        CLS_LSB = 2'd2
    } disp_class_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic disp_class_e class_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE:                  return CLS_LSB;
            OP_OP, OP_OPIMM, OP_BRANCH, OP_JALR: return CLS_RS;
            default:                            return CLS_ROB;
        endcase
    endfunction

    function automatic imm_fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_FENCE, OP_SYSTEM: return FMT_I;
            OP_STORE:                                       return FMT_S;
            OP_BRANCH:                                      return FMT_B;
            OP_LUI, OP_AUIPC:                               return FMT_U;
            OP_JAL:                                         return FMT_J;
            default:                                        return FMT_R;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        case (fmt_of(w[6:0]))
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'b0};
            FMT_J:   return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // Operands the encoding does not read are forced ready with value 0.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_JAL || op == OP_LUI || op == OP_AUIPC);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return !(op == OP_LOAD || op == OP_OPIMM || op == OP_JALR ||
                 op == OP_JAL  || op == OP_LUI   || op == OP_AUIPC);
    endfunction

    // Stores and branches carry immediate bits in the rd field, so they must
    // not be treated as producers by the bypass path.
    function automatic logic has_rd(input logic [6:0] op);
        return is_legal(op) && op != OP_STORE && op != OP_BRANCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_operand.sv
`default_nettype none
// ============================================================================
//  Module      : issue_operand
//  Description : One source operand of the issue stage. Resolves the operand
//                when an instruction is accepted (bypass, x0, RegFile, ROB,
//                CDB, else pending tag) and afterwards captures a matching
//                CDB broadcast while the instruction waits.
//  Ports       : clk/rst/rdy       clock, sync reset, global enable
//                accept/hold       new instruction loads / instruction held
//                idx/used          source register and whether it is read
//                bypass*           destination of the instruction issuing now
//                reg_*/rob_*       RegFile and ROB lookup results
//                cdb_*             result broadcast channels
//                val/tag           registered operand value and rename tag
//  Revision    : 1.0  initial release
// ============================================================================
module issue_operand #(
    parameter int ROB_POS_W = 4,
    parameter int N_CDB     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     accept,
    input  logic                     hold,
    input  logic [4:0]               idx,
    input  logic                     used,
    input  logic                     bypass,
    input  logic [4:0]               bypass_rd,
    input  logic [ROB_POS_W-1:0]     bypass_pos,
    input  logic [31:0]              reg_val,
    input  logic [ROB_POS_W:0]       reg_tag,
    input  logic                     rob_ready,
    input  logic [31:0]              rob_val,
    input  logic [N_CDB-1:0]         cdb_valid,
    input  logic [N_CDB*ROB_POS_W-1:0] cdb_pos,
    input  logic [N_CDB*32-1:0]      cdb_val,
    output logic [31:0]              val,
    output logic [ROB_POS_W:0]       tag
);

    localparam int TAG_W = ROB_POS_W + 1;

    logic [TAG_W-1:0]     r_tag;
    logic [31:0]          r_val;
    logic [ROB_POS_W-1:0] w_srch_pos;
    logic                 w_hit;
    logic [31:0]          w_hit_val;
    logic [TAG_W-1:0]     w_new_tag;
    logic [31:0]          w_new_val;

    // One CDB search serves both paths: at accept it looks for the RegFile
    // tag, otherwise for the tag already held. Lowest channel wins.
    always_comb begin
        w_srch_pos = accept ? reg_tag[ROB_POS_W-1:0] : r_tag[ROB_POS_W-1:0];
        w_hit      = 1'b0;
        w_hit_val  = 32'd0;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && cdb_pos[i*ROB_POS_W +: ROB_POS_W] == w_srch_pos) begin
                w_hit     = 1'b1;
                w_hit_val = cdb_val[i*32 +: 32];
            end
        end
    end

    always_comb begin
        w_new_tag = '0;
        w_new_val = 32'd0;
        if (!used) begin
            w_new_tag = '0;
        end else if (bypass && idx == bypass_rd) begin
            w_new_tag = {1'b1, bypass_pos};
        end else if (idx == 5'd0) begin
            w_new_tag = '0;
        end else if (!reg_tag[TAG_W-1]) begin
            w_new_val = reg_val;
        end else if (rob_ready) begin
            w_new_val = rob_val;
        end else if (w_hit) begin
            w_new_val = w_hit_val;
        end else begin
            w_new_tag = reg_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
            r_val <= 32'd0;
        end else if (rdy) begin
            if (accept) begin
                r_tag <= w_new_tag;
                r_val <= w_new_val;
            end else if (hold && r_tag[TAG_W-1] && w_hit) begin
                r_tag <= '0;
                r_val <= w_hit_val;
            end
        end
    end

    assign val = r_val;
    assign tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/issue_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : issue_decoder
//  Description : RV32I decode/issue stage. Holds one decoded instruction
//                under a valid/ready handshake, renames its operands, tracks
//                CDB results while it waits and dispatches to ROB/RS/LSB.
//  Ports       : inst_*        fetcher handshake, instruction and PC
//                reg_*/rob_*   RegFile and ROB operand lookups
//                *_full        back-pressure from ROB, RS, LSB
//                cdb_*         N_CDB result broadcast channels
//                issue/rs_en/lsb_en  dispatch pulses
//                opcode..illegal     decoded fields of the held instruction
//  Revision    : 1.0  initial release
// ============================================================================
module issue_decoder
    import issue_decoder_pkg::*;
#(
    parameter int ROB_POS_W = DEF_ROB_POS_W,
    parameter int N_CDB     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       rollback,
    input  logic                       inst_valid,
    output logic                       inst_ready,
    input  logic [31:0]                inst,
    input  logic [31:0]                inst_pc,
    output logic [4:0]                 reg_rs1,
    output logic [4:0]                 reg_rs2,
    input  logic [31:0]                reg_rs1_val,
    input  logic [31:0]                reg_rs2_val,
    input  logic [ROB_POS_W:0]         reg_rs1_tag,
    input  logic [ROB_POS_W:0]         reg_rs2_tag,
    output logic [ROB_POS_W-1:0]       rob_rs1_pos,
    output logic [ROB_POS_W-1:0]       rob_rs2_pos,
    input  logic                       rob_rs1_ready,
    input  logic                       rob_rs2_ready,
    input  logic [31:0]                rob_rs1_val,
    input  logic [31:0]                rob_rs2_val,
    input  logic                       rob_full,
    input  logic                       rs_full,
    input  logic                       lsb_full,
    input  logic [ROB_POS_W-1:0]       nxt_rob_pos,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [N_CDB*ROB_POS_W-1:0] cdb_pos,
    input  logic [N_CDB*32-1:0]        cdb_val,
    output logic                       issue,
    output logic                       rs_en,
    output logic                       lsb_en,
    output logic [ROB_POS_W-1:0]       rob_pos,
    output logic [6:0]                 opcode,
    output logic [2:0]                 funct3,
    output logic                       funct7,
    output logic [31:0]                rs1_val,
    output logic [31:0]                rs2_val,
    output logic [ROB_POS_W:0]         rs1_tag,
    output logic [ROB_POS_W:0]         rs2_tag,
    output logic [31:0]                imm,
    output logic [4:0]                 rd,
    output logic [31:0]                pc,
    output logic                       illegal
);

    logic        r_held;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    disp_class_e w_cls;
    logic        w_fire;
    logic        w_accept;
    logic [4:0]  w_held_rd;
    logic        w_bypass;

    assign w_cls     = class_of(r_inst[6:0]);
    assign w_held_rd = has_rd(r_inst[6:0]) ? r_inst[11:7] : 5'd0;

    assign w_fire = rdy && !rollback && r_held && !rob_full
                  && !(w_cls == CLS_RS  && rs_full)
                  && !(w_cls == CLS_LSB && lsb_full);

    assign inst_ready = rdy && !rollback && (!r_held || w_fire);
    assign w_accept   = inst_valid && inst_ready;

    // The issuing instruction's rd is not yet visible in the RegFile, so an
    // instruction accepted in the same cycle must rename to its ROB slot.
    assign w_bypass = w_fire && (w_held_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= 1'b0;
            r_inst <= 32'd0;
            r_pc   <= 32'd0;
        end else if (rdy) begin
            if (rollback) begin
                r_held <= 1'b0;
            end else begin
                r_held <= w_accept || (r_held && !w_fire);
                if (w_accept) begin
                    r_inst <= inst;
                    r_pc   <= inst_pc;
                end
            end
        end
    end

    issue_operand #(
        .ROB_POS_W (ROB_POS_W),
        .N_CDB     (N_CDB)
    ) u_op_rs1 (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .accept     (w_accept),
        .hold       (r_held),
        .idx        (inst[19:15]),
        .used       (uses_rs1(inst[6:0])),
        .bypass     (w_bypass),
        .bypass_rd  (w_held_rd),
        .bypass_pos (nxt_rob_pos),
        .reg_val    (reg_rs1_val),
        .reg_tag    (reg_rs1_tag),
        .rob_ready  (rob_rs1_ready),
        .rob_val    (rob_rs1_val),
        .cdb_valid  (cdb_valid),
        .cdb_pos    (cdb_pos),
        .cdb_val    (cdb_val),
        .val        (rs1_val),
        .tag        (rs1_tag)
    );

    issue_operand #(
        .ROB_POS_W (ROB_POS_W),
        .N_CDB     (N_CDB)
    ) u_op_rs2 (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .accept     (w_accept),
        .hold       (r_held),
        .idx        (inst[24:20]),
        .used       (uses_rs2(inst[6:0])),
        .bypass     (w_bypass),
        .bypass_rd  (w_held_rd),
        .bypass_pos (nxt_rob_pos),
        .reg_val    (reg_rs2_val),
        .reg_tag    (reg_rs2_tag),
        .rob_ready  (rob_rs2_ready),
        .rob_val    (rob_rs2_val),
        .cdb_valid  (cdb_valid),
        .cdb_pos    (cdb_pos),
        .cdb_val    (cdb_val),
        .val        (rs2_val),
        .tag        (rs2_tag)
    );

    assign reg_rs1     = inst[19:15];
    assign reg_rs2     = inst[24:20];
    assign rob_rs1_pos = reg_rs1_tag[ROB_POS_W-1:0];
    assign rob_rs2_pos = reg_rs2_tag[ROB_POS_W-1:0];

    assign issue   = w_fire;
    assign rs_en   = w_fire && (w_cls == CLS_RS);
    assign lsb_en  = w_fire && (w_cls == CLS_LSB);
    assign rob_pos = nxt_rob_pos;

    assign opcode  = r_inst[6:0];
    assign funct3  = r_inst[14:12];
    assign funct7  = r_inst[30];
    assign imm     = imm_of(r_inst);
    assign rd      = w_held_rd;
    assign pc      = r_pc;
    assign illegal = !is_legal(r_inst[6:0]);

endmodule
`default_nettype wire
